pc_fetch_unit: RTL

Program-counter and instruction-fetch stage of the RISC-V pipeline. It holds the PC and issues requests to instruction memory. It latches each returned instruction into the IF/ID register. It consumes the branch-target address from the branch adder and the jump target from decode. if_id_pc travels down the pipeline and becomes the branch adder's current-PC operand.

---
 rtl/pc_fetch_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage.
// Holds the PC and issues single-outstanding requests to instruction memory.
// It captures each response into the IF/ID register. Branch and jump redirects
// are taken from the EX and ID stages.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic        jump_taken,
    input  logic [31:0] jump_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misaligned_fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;        // redirect target parked while DRAIN waits
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;
    logic        r_fault;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic [31:0] w_pc_inc;

    logic [2:0]  w_state_n;
    logic [31:0] w_pc_n;
    logic [31:0] w_tgt_n;
    logic [31:0] w_hold_pc_n;
    logic [31:0] w_hold_instr_n;
    logic [31:0] w_if_pc_n;
    logic [31:0] w_if_instr_n;
    logic        w_if_valid_n;
    logic        w_fault_n;

    // Branch comes from the older instruction, so it wins over a jump.
    assign w_redirect   = branch_taken | jump_taken;
    assign w_target     = branch_taken ? branch_pc : jump_pc;
    assign w_misaligned = |w_target[1:0];
    assign w_pc_inc     = r_pc + 32'd4;

    // The request address is always r_pc. In DRAIN, r_pc still holds the old address.
    assign imem_req         = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imem_addr        = r_pc;
    assign pc               = r_pc;
    assign if_id_pc         = r_if_pc;
    assign if_id_instr      = r_if_instr;
    assign if_id_valid      = r_if_valid;
    assign misaligned_fault = r_fault;

    // Next-state logic: a redirect overrides stall and flushes IF/ID.
    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_tgt_n        = r_tgt;
        w_hold_pc_n    = r_hold_pc;
        w_hold_instr_n = r_hold_instr;
        w_if_pc_n      = r_if_pc;
        w_if_instr_n   = r_if_instr;
        w_if_valid_n   = r_if_valid;
        w_fault_n      = r_fault;

        if (r_state != S_FAULT && w_redirect) begin
            w_if_valid_n = 1'b0;
            w_if_instr_n = NOP_INSTR;
            if (w_misaligned) begin
                w_state_n = S_FAULT;
                w_fault_n = 1'b1;
            end else if ((r_state == S_FETCH || r_state == S_DRAIN) && !imem_ready) begin
                // A response is still owed to the old address, so let it arrive and drop it.
                w_state_n = S_DRAIN;
                w_tgt_n   = w_target;
            end else begin
                w_pc_n    = w_target;
                w_state_n = S_FETCH;
            end
        end else begin
            case (r_state)
                S_IDLE: w_state_n = S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        if (!stall) begin
                            w_if_pc_n    = r_pc;
                            w_if_instr_n = imem_rdata;
                            w_if_valid_n = 1'b1;
                            w_pc_n       = w_pc_inc;
                        end else begin
                            w_hold_pc_n    = r_pc;
                            w_hold_instr_n = imem_rdata;
                            w_state_n      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_if_pc_n    = r_hold_pc;
                        w_if_instr_n = r_hold_instr;
                        w_if_valid_n = 1'b1;
                        w_pc_n       = w_pc_inc;
                        w_state_n    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        w_pc_n    = r_tgt;
                        w_state_n = S_FETCH;
                    end
                end
                S_FAULT: begin
                    w_if_valid_n = 1'b0;
                    w_fault_n    = 1'b1;
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // State and pipeline registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_VECTOR;
            r_tgt        <= RESET_VECTOR;
            r_hold_pc    <= 32'd0;
            r_hold_instr <= NOP_INSTR;
            r_if_pc      <= 32'd0;
            r_if_instr   <= NOP_INSTR;
            r_if_valid   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_tgt        <= w_tgt_n;
            r_hold_pc    <= w_hold_pc_n;
            r_hold_instr <= w_hold_instr_n;
            r_if_pc      <= w_if_pc_n;
            r_if_instr   <= w_if_instr_n;
            r_if_valid   <= w_if_valid_n;
            r_fault      <= w_fault_n;
        end
    end

endmodule
